seq_shift_unit: RTL

Parametrised multi-cycle shift engine that generalises the 8-bit load/shift-right register. It loads a WIDTH-bit operand, then shifts it one position per clock, for up to WIDTH-1 positions, in a selectable direction and mode. Completion is signalled with a start/busy/done handshake. It sits in the datapath as the sequential shifter serving ALU shift and rotate instructions.

---
 rtl/seq_shift_unit_if.sv | 27 ++
 rtl/seq_shift_unit.sv | 135 +++++++++++++
 2 files changed

// File: rtl/seq_shift_unit_if.sv
// Operand/result bundle for seq_shift_unit: master issues start with operand and shift controls,
// slave returns the register contents, the last shifted-out bit and the busy/done status.
interface seq_shift_unit_if #(
  parameter int WIDTH = 8
);
  localparam int SHW = $clog2(WIDTH);

  logic             start;
  logic [WIDTH-1:0] in;
  logic [SHW-1:0]   shamt;
  logic             dir;
  logic [1:0]       mode;
  logic [WIDTH-1:0] out;
  logic             serial_out;
  logic             busy;
  logic             done;

  modport master (
    output start, in, shamt, dir, mode,
    input  out, serial_out, busy, done
  );

  modport slave (
    input  start, in, shamt, dir, mode,
    output out, serial_out, busy, done
  );
endinterface

// File: rtl/seq_shift_unit.sv
// Multi-cycle shifter: done shamt+1 edges after accept (1 if shamt==0); start ignored while busy.
// SEQ_SHIFT_BARREL_EN: whole shift in one edge (done 2 edges after accept for shamt!=0).
module seq_shift_unit #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  seq_shift_unit_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             serial_out_q, serial_out_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [1:0]       mode_q, mode_d;

  logic [WIDTH-1:0] shift_out;
  logic             shift_bit;

`ifdef SEQ_SHIFT_BARREL_EN
  logic [2*WIDTH-1:0] dbl, rot_r, rot_l;

  // Rotation uses a doubled copy so a plain shift carries the wrapped bits along.
  always_comb begin
    dbl       = {out_q, out_q};
    rot_r     = dbl >> cnt_q;
    rot_l     = dbl << cnt_q;
    shift_out = out_q;
    shift_bit = 1'b0;
    if (!dir_q) begin
      shift_bit = out_q[cnt_q - 1'b1];
      if (mode_q == 2'b01)
        shift_out = WIDTH'($signed(out_q) >>> cnt_q);
      else if (mode_q == 2'b10)
        shift_out = rot_r[WIDTH-1:0];
      else
        shift_out = out_q >> cnt_q;
    end else begin
      shift_bit = out_q[WIDTH - int'(cnt_q)];
      if (mode_q == 2'b10)
        shift_out = rot_l[2*WIDTH-1:WIDTH];
      else
        shift_out = out_q << cnt_q;
    end
  end
`else
  logic fill;

  always_comb begin
    fill      = 1'b0;
    shift_out = out_q;
    shift_bit = 1'b0;
    if (!dir_q) begin
      if (mode_q == 2'b01)
        fill = out_q[WIDTH-1];
      else if (mode_q == 2'b10)
        fill = out_q[0];
      shift_out = {fill, out_q[WIDTH-1:1]};
      shift_bit = out_q[0];
    end else begin
      if (mode_q == 2'b10)
        fill = out_q[WIDTH-1];
      shift_out = {out_q[WIDTH-2:0], fill};
      shift_bit = out_q[WIDTH-1];
    end
  end
`endif

  always_comb begin
    state_d      = state_q;
    out_d        = out_q;
    serial_out_d = serial_out_q;
    cnt_d        = cnt_q;
    dir_d        = dir_q;
    mode_d       = mode_q;

    case (state_q)
      SHIFT: begin
        out_d        = shift_out;
        serial_out_d = shift_bit;
`ifdef SEQ_SHIFT_BARREL_EN
        cnt_d        = '0;
        state_d      = DONE;
`else
        cnt_d        = cnt_q - 1'b1;
        if (cnt_q == SHW'(1))
          state_d = DONE;
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = state_q;
    endcase

    // Acceptance in DONE overrides the return to IDLE, giving back-to-back operations.
    if (state_q != SHIFT && bus.start) begin
      out_d        = bus.in;
      serial_out_d = 1'b0;
      cnt_d        = bus.shamt;
      dir_d        = bus.dir;
      mode_d       = bus.mode;
      state_d      = (bus.shamt == '0) ? DONE : SHIFT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      out_q        <= '0;
      serial_out_q <= 1'b0;
      cnt_q        <= '0;
      dir_q        <= 1'b0;
      mode_q       <= 2'b00;
    end else begin
      state_q      <= state_d;
      out_q        <= out_d;
      serial_out_q <= serial_out_d;
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      mode_q       <= mode_d;
    end
  end

  assign bus.out        = out_q;
  assign bus.serial_out = serial_out_q;
  assign bus.busy       = (state_q == SHIFT);
  assign bus.done       = (state_q == DONE);
endmodule
